// File: rtl/vga_note_scheduler.sv
// Drives the VGA pixel port for one note label (erase box, then sharp/letter/octave
// glyphs at 12-pixel pitch) and for the full-screen clear, one pixel per clock.
module vga_note_scheduler #(
  parameter logic [2:0] FG_COLOUR = 3'b100,
  parameter logic [2:0] BG_COLOUR = 3'b000,
  parameter int         SCREEN_W  = 160,
  parameter int         SCREEN_H  = 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        clear_req,
  input  logic [3:0]  note,
  input  logic [1:0]  octave,
  input  logic [7:0]  x,
  input  logic [6:0]  y,
  output logic [3:0]  glyph_sel,
  output logic [3:0]  glyph_row,
  input  logic [11:0] glyph_bits,
  output logic [7:0]  x_out,
  output logic [6:0]  y_out,
  output logic [2:0]  colour,
  output logic        writeEn,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, CLEAR, ERASE, SHARP, LETTER, OCT, FIN} state_t;

  state_t      state, next_state;
  logic [7:0]  col, col_max, base_x;
  logic [6:0]  row, row_max, base_y;
  logic [3:0]  note_q, letter_idx, next_sel, bit_idx;
  logic [1:0]  oct_q;
  logic [7:0]  x_q;
  logic [6:0]  y_q;
  logic [4:0]  slot_off;
  logic [8:0]  px;
  logic [7:0]  py;
  logic        note_valid, note_sharp, glyph_state, in_range, last, glyph_bit;

  always_comb begin
    letter_idx = 4'd0;
    note_sharp = 1'b0;
    note_valid = 1'b1;
    case (note_q)
      4'd1:  letter_idx = 4'd0;
      4'd2:  begin letter_idx = 4'd0; note_sharp = 1'b1; end
      4'd3:  letter_idx = 4'd1;
      4'd4:  letter_idx = 4'd2;
      4'd5:  begin letter_idx = 4'd2; note_sharp = 1'b1; end
      4'd6:  letter_idx = 4'd3;
      4'd7:  begin letter_idx = 4'd3; note_sharp = 1'b1; end
      4'd8:  letter_idx = 4'd4;
      4'd9:  letter_idx = 4'd5;
      4'd10: begin letter_idx = 4'd5; note_sharp = 1'b1; end
      4'd11: letter_idx = 4'd6;
      4'd12: begin letter_idx = 4'd6; note_sharp = 1'b1; end
      default: note_valid = 1'b0;
    endcase
  end

  // Scan geometry per state; the ROM address is a direct decode of the counters.
  always_comb begin
    col_max  = 8'd11;
    row_max  = 7'd11;
    slot_off = 5'd0;
    base_x   = x_q;
    base_y   = y_q;
    case (state)
      CLEAR: begin
        col_max = 8'(SCREEN_W - 1);
        row_max = 7'(SCREEN_H - 1);
        base_x  = 8'd0;
        base_y  = 7'd0;
      end
      ERASE:   col_max  = 8'd35;
      LETTER:  slot_off = 5'd12;
      OCT:     slot_off = 5'd24;
      default: ;
    endcase
    glyph_state = (state == SHARP) || (state == LETTER) || (state == OCT);
    glyph_row   = glyph_state ? row[3:0] : 4'd0;
    px          = {1'b0, base_x} + {1'b0, col} + {4'd0, slot_off};
    py          = {1'b0, base_y} + {1'b0, row};
    in_range    = (px <= 9'(SCREEN_W - 1)) && (py <= 8'(SCREEN_H - 1));
    bit_idx     = 4'd11 - col[3:0];
    glyph_bit   = glyph_bits[bit_idx];
    last        = (col == col_max) && (row == row_max);
  end

  always_comb begin
    next_state = FIN;
    next_sel   = 4'd0;
    case (state)
      ERASE: begin
        if (!note_valid)     next_state = FIN;
        else if (note_sharp) begin next_state = SHARP;  next_sel = 4'd7;       end
        else                 begin next_state = LETTER; next_sel = letter_idx; end
      end
      SHARP:   begin next_state = LETTER; next_sel = letter_idx; end
      LETTER:  begin next_state = OCT;    next_sel = 4'd8 + {2'b00, oct_q}; end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

  // NOTE: every register here, including the latched label inputs, is cleared by the
  // asynchronous reset so an aborted operation leaves no stale state behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      col       <= 8'd0;
      row       <= 7'd0;
      note_q    <= 4'd0;
      oct_q     <= 2'd0;
      x_q       <= 8'd0;
      y_q       <= 7'd0;
      glyph_sel <= 4'd0;
      x_out     <= 8'd0;
      y_out     <= 7'd0;
      colour    <= BG_COLOUR;
      writeEn   <= 1'b0;
      done      <= 1'b0;
    end else begin
      writeEn <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          col <= 8'd0;
          row <= 7'd0;
          if (clear_req) begin
            state <= CLEAR;
          end else if (start) begin
            note_q <= note;
            oct_q  <= octave;
            x_q    <= x;
            y_q    <= y;
            state  <= ERASE;
          end
        end
        FIN: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          // Clipped pixels still consume their cycle so timing is position independent.
          x_out   <= px[7:0];
          y_out   <= py[6:0];
          colour  <= glyph_state ? FG_COLOUR : BG_COLOUR;
          writeEn <= in_range && (!glyph_state || glyph_bit);
          if (last) begin
            col       <= 8'd0;
            row       <= 7'd0;
            state     <= next_state;
            glyph_sel <= next_sel;
          end else if (col == col_max) begin
            col <= 8'd0;
            row <= row + 7'd1;
          end else begin
            col <= col + 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_note_scheduler.sv
// Table-driven bench for vga_note_scheduler: per-cycle pixel model, done timing,
// clipping, clear priority, busy-time start rejection and mid-operation reset.
module tb_vga_note_scheduler;

  localparam logic [2:0] FG = 3'b100;
  localparam logic [2:0] BG = 3'b000;

  logic        clk = 1'b0;
  logic        reset, start, clear_req;
  logic [3:0]  note;
  logic [1:0]  octave;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [3:0]  glyph_sel, glyph_row;
  logic [11:0] glyph_bits;
  logic [7:0]  x_out;
  logic [6:0]  y_out;
  logic [2:0]  colour;
  logic        writeEn, busy, done;

  int total = 0;
  int bad   = 0;
  int errs, first_err;

  vga_note_scheduler dut (
    .clk(clk), .reset(reset), .start(start), .clear_req(clear_req),
    .note(note), .octave(octave), .x(x), .y(y),
    .glyph_sel(glyph_sel), .glyph_row(glyph_row), .glyph_bits(glyph_bits),
    .x_out(x_out), .y_out(y_out), .colour(colour), .writeEn(writeEn),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // External glyph ROM stand-in: every glyph/row gets a distinct, irregular pattern.
  function automatic logic [11:0] rom(input logic [3:0] s, input logic [3:0] r);
    return {s, r, s ^ r};
  endfunction

  assign glyph_bits = rom(glyph_sel, glyph_row);

  typedef struct {
    logic       clr;
    logic       st;
    logic [3:0] note;
    logic [1:0] oct;
    logic [7:0] x;
    logic [6:0] y;
    int         n;       // cycles from start sample to FIN
    int         exp_bg;  // background writes
    int         exp_fg;  // foreground writes, -1 = not checked
    int         poke;    // cycle at which to pulse start while busy, 0 = none
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic note_err(input int k);
    errs++;
    if (first_err < 0) first_err = k;
  endtask

  function automatic int letter_of(input logic [3:0] n);
    case (n)
      4'd1, 4'd2:   return 0;
      4'd3:         return 1;
      4'd4, 4'd5:   return 2;
      4'd6, 4'd7:   return 3;
      4'd8:         return 4;
      4'd9, 4'd10:  return 5;
      default:      return 6;
    endcase
  endfunction

  function automatic bit sharp_of(input logic [3:0] n);
    return (n == 4'd2) || (n == 4'd5) || (n == 4'd7) || (n == 4'd10) || (n == 4'd12);
  endfunction

  // Expected pixel for scan index i (0 = first pixel after the start sample).
  task automatic model(input vec_t v, input int i, output logic we, output int xo,
                       output int yo, output logic [2:0] c, output logic g,
                       output int sel, output int rw);
    int j, p, pix, c0, slot;
    logic [11:0] bits;
    g = 1'b0; sel = 0; rw = 0;
    if (v.clr) begin
      xo = i % 160; yo = i / 160; we = 1'b1; c = BG;
    end else if (i < 432) begin
      xo = int'(v.x) + i % 36; yo = int'(v.y) + i / 36;
      we = (xo < 160) && (yo < 120); c = BG;
    end else begin
      j = i - 432; p = j / 144; pix = j % 144; c0 = pix % 12; rw = pix / 12;
      if (sharp_of(v.note)) begin
        sel  = (p == 0) ? 7 : (p == 1) ? letter_of(v.note) : 8 + int'(v.oct);
        slot = p * 12;
      end else begin
        sel  = (p == 0) ? letter_of(v.note) : 8 + int'(v.oct);
        slot = (p + 1) * 12;
      end
      xo   = int'(v.x) + slot + c0; yo = int'(v.y) + rw;
      bits = rom(4'(sel), 4'(rw));
      we   = bits[11 - c0] && (xo < 160) && (yo < 120);
      c    = FG; g = 1'b1;
    end
  endtask

  task automatic run(input vec_t v, input int idx);
    int bg, fg, oob, dn, done_k, lx, ly, xo, yo, sel, rw;
    logic we, g;
    logic [2:0] c;
    errs = 0; first_err = -1; bg = 0; fg = 0; oob = 0; dn = 0; done_k = -1; lx = -1; ly = -1;
    note = v.note; octave = v.oct; x = v.x; y = v.y;
    start = v.st; clear_req = v.clr;
    @(posedge clk); #1;
    start = 1'b0; clear_req = 1'b0;
    for (int k = 1; k <= v.n + 2; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (k <= v.n) begin
        model(v, k - 1, we, xo, yo, c, g, sel, rw);
        if (writeEn !== we) note_err(k);
        else if (we && (int'(x_out) != xo || int'(y_out) != yo || colour !== c)) note_err(k);
      end else if (writeEn !== 1'b0) note_err(k);
      if (busy !== ((k <= v.n) ? 1'b1 : 1'b0)) note_err(k);
      if (done === 1'b1) begin
        dn++;
        if (done_k < 0) done_k = k;
      end
      if (writeEn === 1'b1) begin
        if (colour == BG) bg++; else fg++;
        if (x_out > 8'd159 || y_out > 7'd119) oob++;
        lx = int'(x_out); ly = int'(y_out);
      end
      if (k < v.n && !v.clr) begin
        model(v, k, we, xo, yo, c, g, sel, rw);
        if (g && (int'(glyph_sel) != sel || int'(glyph_row) != rw)) note_err(k);
      end
      if (k == v.poke) start = 1'b1;
    end
    check($sformatf("v%0d done_cycle", idx), done_k, v.n + 1);
    check($sformatf("v%0d done_pulses", idx), dn, 1);
    check($sformatf("v%0d pixel_stream first_k=%0d", idx, first_err), errs, 0);
    check($sformatf("v%0d bg_writes", idx), bg, v.exp_bg);
    check($sformatf("v%0d out_of_bounds", idx), oob, 0);
    if (v.exp_fg >= 0) check($sformatf("v%0d fg_writes", idx), fg, v.exp_fg);
    if (v.clr) begin
      check($sformatf("v%0d last_x", idx), lx, 159);
      check($sformatf("v%0d last_y", idx), ly, 119);
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, 4'd5,  2'd2, 8'd10,  7'd20,  864,   432,   -1, 0};
    vecs[1] = '{1'b0, 1'b1, 4'd3,  2'd0, 8'd10,  7'd20,  720,   432,   -1, 300};
    vecs[2] = '{1'b0, 1'b1, 4'd0,  2'd1, 8'd40,  7'd50,  432,   432,   0,  0};
    vecs[3] = '{1'b0, 1'b1, 4'd14, 2'd3, 8'd0,   7'd0,   432,   432,   0,  0};
    vecs[4] = '{1'b0, 1'b1, 4'd1,  2'd1, 8'd150, 7'd115, 720,   50,    -1, 0};
    vecs[5] = '{1'b0, 1'b1, 4'd12, 2'd3, 8'd0,   7'd0,   864,   432,   -1, 0};
    vecs[6] = '{1'b0, 1'b1, 4'd9,  2'd1, 8'd124, 7'd108, 720,   432,   -1, 0};
    vecs[7] = '{1'b1, 1'b1, 4'd5,  2'd2, 8'd10,  7'd20,  19200, 19200, 0,  500};

    reset = 1'b1; start = 1'b0; clear_req = 1'b0;
    note = 4'd0; octave = 2'd0; x = 8'd0; y = 7'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst writeEn", writeEn, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst x_out", x_out, 0);
    check("rst y_out", y_out, 0);
    check("rst colour", colour, BG);
    check("rst glyph_sel", glyph_sel, 0);
    check("rst glyph_row", glyph_row, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run(vecs[i], i);
      repeat (3) @(posedge clk);
      #1;
    end

    // Abort in the LETTER phase of a sharp note, then confirm the block stays idle.
    note = 4'd5; octave = 2'd2; x = 8'd10; y = 7'd20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (432 + 144 + 40) @(posedge clk);
    #1;
    check("pre_abort busy", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    check("abort writeEn", writeEn, 0);
    check("abort busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    errs = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (writeEn !== 1'b0 || busy !== 1'b0 || done !== 1'b0) errs++;
    end
    check("post_abort idle", errs, 0);
    run(vecs[0], 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_note_scheduler.md
Name: vga_note_scheduler

Overview:
- Sequences the 12x12 glyph plotter path for one on-screen note label: erases a 36x12 box, then plots sharp, letter and octave glyphs left to right at 12-pixel pitch.
- Also owns the full-screen clear.
- Sits between the note/octave source and the VGA adapter pixel port, emitting one pixel write per clock.
- Glyph bitmaps come from an external combinational glyph ROM addressed by this block.

Parameters:
- FG_COLOUR, 3'b100, colour of set glyph pixels.
- BG_COLOUR, 3'b000, colour for erase and full clear.
- SCREEN_W, 160, screen width in pixels.
- SCREEN_H, 120, screen height in pixels.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to draw a label; sampled only in IDLE.
- clear_req  in  1  one-cycle request to clear the full screen; sampled only in IDLE, wins over start.
- note  in  4  1=A, 2=A#, 3=B, 4=C, 5=C#, 6=D, 7=D#, 8=E, 9=F, 10=F#, 11=G, 12=G#; other values are invalid.
- octave  in  2  octave 0..3, displayed as digit 1..4.
- x  in  8  label top-left X.
- y  in  7  label top-left Y.
- glyph_sel  out  4  ROM glyph index: 0..6 = letters A..G, 7 = sharp, 8..11 = digits 1..4.
- glyph_row  out  4  ROM row 0..11; row 0 is the top row.
- glyph_bits  in  12  ROM row data, combinational, same cycle; bit 11 is the leftmost pixel.
- x_out  out  8  pixel X to adapter.
- y_out  out  7  pixel Y to adapter.
- colour  out  3  pixel colour.
- writeEn  out  1  pixel write strobe.
- busy  out  1  high in any non-IDLE state.
- done  out  1  one-cycle pulse when an operation completes.

Behaviour:
- Reset (async): state=IDLE. writeEn=0, done=0, busy=0, x_out=0, y_out=0, colour=BG_COLOUR, glyph_sel=0, glyph_row=0. All counters and latched inputs are cleared.
  - Reset mid-operation aborts immediately. No further writes occur.
- States: IDLE, CLEAR, ERASE, SHARP, LETTER, OCT, FIN.
- IDLE:
  - clear_req=1 → CLEAR.
  - Otherwise start=1 → latch note, octave, x, y, then go to ERASE.
  - start or clear_req while not IDLE is ignored and not queued.
- Pixel counters: col 0..11, row 0..11, advancing raster order (col first), one pixel per cycle. ERASE uses col 0..35.
- CLEAR:
  - Scans X 0..SCREEN_W-1 and Y 0..SCREEN_H-1 (19200 pixels).
  - writeEn=1, colour=BG_COLOUR for every pixel.
  - → FIN.
- ERASE:
  - 36x12 = 432 pixels at (x+col, y+row).
  - writeEn=1, colour=BG_COLOUR.
  - Invalid note → FIN.
  - Sharp note → SHARP.
  - Natural note → LETTER.
- SHARP: glyph_sel=7, slot 0 (X offset 0) → LETTER.
- LETTER: glyph_sel=letter index, slot 1 (X offset 12) → OCT.
- OCT: glyph_sel=8+octave, slot 2 (X offset 24) → FIN.
- Glyph states:
  - 144 cycles each; glyph_row=row.
  - writeEn = glyph_bits[11-col], colour=FG_COLOUR when set.
  - Natural notes draw nothing in slot 0; it stays erased.
- Latency:
  - x_out, y_out, colour and writeEn are registered, one cycle after the counter state that produced them.
  - start sampled at edge E0 → first pixel valid after E1.
- FIN: lasts one cycle, drives no writes, asserts done=1 registered, then → IDLE.
- Cycle counts, from start sample to done pulse, excluding the FIN cycle:
  - Sharp note: 864.
  - Natural note: 720.
  - Invalid note: 432.
  - Clear: 19200.
- Clipping:
  - Compute coordinates at 9/8 bits.
  - If x+offset > SCREEN_W-1 or y+row > SCREEN_H-1, force writeEn=0 for that pixel. Sequencing and timing are unchanged; no wrap-around writes occur.
- Outside write cycles, writeEn=0.

Test Plan:
- Reset, then start with note=5 (C#), octave=2, x=10, y=20:
  - 432 BG writes covering X 10..45, Y 20..31.
  - Then glyph_sel sequence 7, 2, 10, each for 144 cycles.
  - writeEn pattern matches the ROM bits.
  - done pulses exactly 1 cycle, 865 cycles after start.
- note=3 (B), octave=0:
  - No glyph_sel=7 phase.
  - Letter writes land at X x+12..x+23, digit "1" writes at x+24..x+35.
  - done at cycle 721.
- note=0 and note=14:
  - Only the 432-pixel erase, then done.
  - No FG_COLOUR writes.
- x=150, y=115, note=1:
  - No write with x_out>159 or y_out>119.
  - done timing is identical to the unclipped case.
- clear_req and start in the same IDLE cycle:
  - 19200 BG writes; the last is (159,119).
  - start is dropped.
  - A start pulsed while busy is ignored.
- Assert reset during the LETTER phase:
  - writeEn and busy go to 0 asynchronously.
  - Idle until the next start, which then runs a full normal sequence.
